// File: rtl/ret_predictor.sv
// Return-address predictor: drives an external RAS from fetch and tracks unresolved returns until execute resolves them.
// Strobes/prediction/stall are same-cycle combinational; status pulses and counters register one cycle later; fetch stalls on full tracker.
module ret_predictor #(
    parameter int FIFO_DEPTH = 4,
    parameter int RAS_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic        fetch_is_call,
    input  logic        fetch_is_ret,
    input  logic [15:0] fetch_pc,
    output logic        ras_push,
    output logic [15:0] ras_new_data,
    output logic        ras_pop,
    input  logic [15:0] ras_top,
    output logic        pred_valid,
    output logic [15:0] pred_target,
    output logic        stall_fetch,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_target,
    input  logic        flush,
    output logic        mispredict,
    output logic        resolve_err,
    output logic        overflow,
    output logic [3:0]  depth,
    output logic [7:0]  mispredict_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    RAS_FULL  = 4'(RAS_DEPTH);

    typedef struct packed {
        logic        predicted;
        logic [15:0] target;
    } ret_entry_t;

    ret_entry_t    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic acc_call;
    logic acc_ret;
    logic deq;
    logic head_miss;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // A ret with call also set is a ret only, so push and pop are mutually exclusive.
    always_comb begin
        stall_fetch  = (count == FIFO_FULL);
        acc_ret      = fetch_valid & fetch_is_ret & ~stall_fetch & ~flush;
        acc_call     = fetch_valid & fetch_is_call & ~fetch_is_ret;
        ras_push     = acc_call && (depth < RAS_FULL);
        ras_new_data = fetch_pc + 16'd1;
        ras_pop      = acc_ret && (depth != 4'd0);
        pred_valid   = ras_pop;
        pred_target  = ras_pop ? ras_top : 16'd0;
        deq          = resolve_valid && (count != '0) && !flush;
        head_miss    = !mem[rd_ptr].predicted || (mem[rd_ptr].target != resolve_target);
    end

    always_ff @(posedge clk) begin
        if (acc_ret)
            mem[wr_ptr] <= '{predicted: ras_pop, target: pred_target};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mispredict  <= 1'b0;
            resolve_err <= 1'b0;
        end else if (flush) begin
            // Flush wins over any same-cycle resolve or enqueue.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mispredict  <= 1'b0;
            resolve_err <= 1'b0;
        end else begin
            if (acc_ret)
                wr_ptr <= ptr_inc(wr_ptr);
            if (deq)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({acc_ret, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            mispredict  <= deq && head_miss;
            resolve_err <= resolve_valid && (count == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth          <= 4'd0;
            overflow       <= 1'b0;
            mispredict_cnt <= 8'd0;
        end else begin
            if (ras_push)
                depth <= depth + 4'd1;
            else if (ras_pop)
                depth <= depth - 4'd1;
            if (acc_call && (depth == RAS_FULL))
                overflow <= 1'b1;
            if (deq && head_miss && (mispredict_cnt != 8'hFF))
                mispredict_cnt <= mispredict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ret_predictor.sv
// Directed plus randomized bench for ret_predictor with a queue scoreboard of unresolved returns.
module tb_ret_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_is_call = 1'b0;
    logic        fetch_is_ret = 1'b0;
    logic [15:0] fetch_pc = 16'd0;
    logic        ras_push;
    logic [15:0] ras_new_data;
    logic        ras_pop;
    logic [15:0] ras_top = 16'd0;
    logic        pred_valid;
    logic [15:0] pred_target;
    logic        stall_fetch;
    logic        resolve_valid = 1'b0;
    logic [15:0] resolve_target = 16'd0;
    logic        flush = 1'b0;
    logic        mispredict;
    logic        resolve_err;
    logic        overflow;
    logic [3:0]  depth;
    logic [7:0]  mispredict_cnt;

    ret_predictor #(.FIFO_DEPTH(4), .RAS_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_is_call(fetch_is_call),
        .fetch_is_ret(fetch_is_ret), .fetch_pc(fetch_pc),
        .ras_push(ras_push), .ras_new_data(ras_new_data),
        .ras_pop(ras_pop), .ras_top(ras_top),
        .pred_valid(pred_valid), .pred_target(pred_target),
        .stall_fetch(stall_fetch),
        .resolve_valid(resolve_valid), .resolve_target(resolve_target),
        .flush(flush),
        .mispredict(mispredict), .resolve_err(resolve_err),
        .overflow(overflow), .depth(depth), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic [15:0] t;
    } exp_t;

    exp_t sb[$];
    int   m_depth = 0;
    logic m_ovf = 1'b0;
    int   m_cnt = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_valid = 0; fetch_is_call = 0; fetch_is_ret = 0; fetch_pc = 0;
        ras_top = 0; resolve_valid = 0; resolve_target = 0; flush = 0;
    endtask

    task automatic step(input logic fv, input logic fc, input logic fr, input logic [15:0] pc,
                        input logic [15:0] top, input logic rv, input logic [15:0] rt, input logic fl);
        logic e_stall, a_ret, a_call, e_push, e_pop, e_misp, e_err;
        exp_t h;
        @(negedge clk);
        fetch_valid = fv; fetch_is_call = fc; fetch_is_ret = fr; fetch_pc = pc;
        ras_top = top; resolve_valid = rv; resolve_target = rt; flush = fl;
        #1;
        e_stall = (sb.size() == 4);
        a_ret   = fv & fr & ~e_stall & ~fl;
        a_call  = fv & fc & ~fr;
        e_push  = a_call && (m_depth < 8);
        e_pop   = a_ret && (m_depth > 0);
        chk("stall_fetch", 32'(stall_fetch), 32'(e_stall));
        chk("ras_push", 32'(ras_push), 32'(e_push));
        chk("ras_pop", 32'(ras_pop), 32'(e_pop));
        chk("pred_valid", 32'(pred_valid), 32'(e_pop));
        chk("pred_target", 32'(pred_target), 32'(e_pop ? top : 16'd0));
        if (e_push)
            chk("ras_new_data", 32'(ras_new_data), 32'(16'(pc + 16'd1)));
        e_misp = 0;
        e_err  = 0;
        if (fl) begin
            sb.delete();
        end else begin
            if (rv) begin
                if (sb.size() > 0) begin
                    h = sb.pop_front();
                    e_misp = !h.p || (h.t != rt);
                end else begin
                    e_err = 1;
                end
            end
            if (a_ret) sb.push_back('{p: e_pop, t: (e_pop ? top : 16'd0)});
        end
        if (e_push) m_depth++;
        if (e_pop) m_depth--;
        if (a_call && m_depth == 8 && !e_push) m_ovf = 1;
        if (e_misp && m_cnt < 255) m_cnt++;
        @(posedge clk);
        #1;
        chk("mispredict", 32'(mispredict), 32'(e_misp));
        chk("resolve_err", 32'(resolve_err), 32'(e_err));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("depth", 32'(depth), 32'(m_depth));
        chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
        chk("stall_after", 32'(stall_fetch), 32'(sb.size() == 4));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_depth"}, 32'(depth), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_mcnt"}, 32'(mispredict_cnt), 0);
        chk({tag, "_misp"}, 32'(mispredict), 0);
        chk({tag, "_rerr"}, 32'(resolve_err), 0);
        chk({tag, "_stall"}, 32'(stall_fetch), 0);
    endtask

    initial begin
        idle_inputs();
        #3;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1;

        // Call then predicted ret, resolved correctly.
        step(1, 1, 0, 16'h0100, 16'h0, 0, 16'h0, 0);
        chk("call_depth", 32'(depth), 1);
        step(1, 0, 1, 16'h0200, 16'h0101, 0, 16'h0, 0);
        chk("ret_depth", 32'(depth), 0);
        step(0, 0, 0, 16'h0, 16'h0, 1, 16'h0101, 0);
        chk("good_resolve_misp", 32'(mispredict), 0);

        // Ret on empty stack, then resolve: unpredicted so it mispredicts.
        step(1, 0, 1, 16'h0300, 16'h7777, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 16'h0, 1, 16'h0200, 0);
        chk("empty_ret_misp", 32'(mispredict), 1);
        chk("empty_ret_cnt", 32'(mispredict_cnt), 1);

        // Resolve with nothing outstanding.
        step(0, 0, 0, 16'h0, 16'h0, 1, 16'h0123, 0);
        chk("resolve_err_pulse", 32'(resolve_err), 1);
        step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
        chk("resolve_err_clear", 32'(resolve_err), 0);

        // Nine calls overflow an 8-deep stack.
        for (int i = 0; i < 9; i++)
            step(1, 1, 0, 16'(16'h0400 + 16 * i), 16'h0, 0, 16'h0, 0);
        chk("nine_calls_depth", 32'(depth), 8);
        chk("nine_calls_ovf", 32'(overflow), 1);

        // Five rets (call bit also set on one) with no resolves: fifth is stalled.
        for (int i = 0; i < 5; i++)
            step(1, (i == 2), 1, 16'h0, 16'(16'h1000 + i), 0, 16'h0, 0);
        chk("five_rets_depth", 32'(depth), 4);
        chk("five_rets_stall", 32'(stall_fetch), 1);

        // Full FIFO: resolve and ret together, ret is ignored.
        step(1, 0, 1, 16'h0, 16'h2222, 1, 16'h1000, 0);
        chk("full_resolve_stall", 32'(stall_fetch), 0);
        chk("full_resolve_depth", 32'(depth), 4);

        // Flush with three entries and a wrong concurrent resolve.
        step(1, 0, 1, 16'h0, 16'h3333, 1, 16'hBEEF, 1);
        chk("flush_misp", 32'(mispredict), 0);
        chk("flush_depth", 32'(depth), 4);
        step(0, 0, 0, 16'h0, 16'h0, 1, 16'h1001, 0);
        chk("post_flush_empty", 32'(resolve_err), 1);

        // Randomized mix exercises pointer wrap and same-cycle enqueue/dequeue.
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));

        // Saturate the mispredict counter with unpredicted rets resolved back to back.
        for (int i = 0; i < 260; i++)
            step(1, 0, 1, 16'h0, 16'h5555, 1, 16'h0200, 0);
        chk("cnt_saturated", 32'(mispredict_cnt), 255);

        // Mid-sequence reset with a live call on the fetch port.
        @(negedge clk);
        fetch_valid = 1; fetch_is_call = 1; fetch_is_ret = 0; fetch_pc = 16'h0300;
        resolve_valid = 0; flush = 0;
        rst_n = 0;
        #1;
        check_reset_state("mid");
        chk("rst_push", 32'(ras_push), 1);
        chk("rst_push_data", 32'(ras_new_data), 32'h0301);
        chk("rst_pop", 32'(ras_pop), 0);
        idle_inputs();
        sb.delete();
        m_depth = 0; m_ovf = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1;
        step(1, 1, 0, 16'h0500, 16'h0, 0, 16'h0, 0);
        step(1, 0, 1, 16'h0, 16'h0501, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 16'h0, 1, 16'h0501, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
